// File: rtl/regfile_write_arbiter_if.sv
// Bundles the signals between the pipeline, the multi-cycle unit, the register file write port and the arbiter.
// The arbiter uses the slave modport; the master modport is the driving side.
interface regfile_write_arbiter_if;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic [4:0]  q_addr;
   logic        q_pending;
   logic        stall_o;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   modport slave (
      input  a_addr, a_data, b_valid, b_addr, b_data, q_addr,
      output b_ready, q_pending, stall_o, wr_addr, wr_data
   );

   modport master (
      output a_addr, a_data, b_valid, b_addr, b_data, q_addr,
      input  b_ready, q_pending, stall_o, wr_addr, wr_data
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between pipeline writeback (A, priority) and a buffered multi-cycle unit (B).
// Optional macro REGFILE_ARB_BYPASS_EN: B writes go straight to the port when the FIFO is empty and A is idle.
module regfile_write_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic                    clk,
   input logic                    reset,
   regfile_write_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] live_q, live_d;
   logic [7:0]       wait_q, wait_d;
   logic             stall_q, stall_d;
   logic [4:0]       addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];

   logic             fifo_empty, head_live, a_active, a_write, head_write;
   logic             bypass_take, ready_int, push, pop;
   logic [DEPTH-1:0] hit_q, hit_a;

   assign fifo_empty = (count_q == '0);
   assign head_live  = !fifo_empty && live_q[rd_ptr_q];
   assign a_active   = (bus.a_addr != 5'd0);
   // While stalled the pipeline is frozen, so its presented write is not real yet.
   assign a_write    = !stall_q && a_active;
   assign head_write = head_live && (stall_q || !a_active);
   assign ready_int  = !reset && (count_q < CW'(DEPTH));

`ifdef REGFILE_ARB_BYPASS_EN
   assign bypass_take = fifo_empty && !stall_q && !a_active && bus.b_valid && (bus.b_addr != 5'd0);
`else
   assign bypass_take = 1'b0;
`endif

   assign push = bus.b_valid && ready_int && (bus.b_addr != 5'd0) && !bypass_take;
   assign pop  = !fifo_empty && (!live_q[rd_ptr_q] || head_write);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         assign hit_q[gi] = live_q[gi] && (addr_mem[gi] == bus.q_addr);
         assign hit_a[gi] = (addr_mem[gi] == bus.a_addr);
      end
   endgenerate

   assign bus.b_ready   = ready_int;
   assign bus.q_pending = (bus.q_addr != 5'd0) && (|hit_q);
   assign bus.stall_o   = stall_q;

   always_comb begin
      bus.wr_addr = 5'd0;
      bus.wr_data = 32'd0;
      if (reset) begin
         bus.wr_addr = 5'd0;
      end else if (stall_q || !a_active) begin
         if (head_live) begin
            bus.wr_addr = addr_mem[rd_ptr_q];
            bus.wr_data = data_mem[rd_ptr_q];
         end else if (bypass_take) begin
            bus.wr_addr = bus.b_addr;
            bus.wr_data = bus.b_data;
         end
      end else begin
         bus.wr_addr = bus.a_addr;
         bus.wr_data = bus.a_data;
      end
   end

   always_comb begin
      live_d   = live_q;
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (pop)
         live_d[rd_ptr_q] = 1'b0;
      // An A write makes any older buffered value for the same register stale.
      if (a_write)
         live_d = live_d & ~hit_a;
      if (push)
         live_d[wr_ptr_q] = !(a_write && (bus.b_addr == bus.a_addr));

      wait_d = wait_q;
      if (pop || fifo_empty)
         wait_d = 8'd0;
      else if (head_live && a_write)
         wait_d = wait_q + 8'd1;
      stall_d = !stall_q && (wait_d == 8'(STARVE_LIMIT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         live_q   <= '0;
         wait_q   <= 8'd0;
         stall_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         live_q   <= live_d;
         wait_q   <= wait_d;
         stall_q  <= stall_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= bus.b_addr;
         data_mem[wr_ptr_q] <= bus.b_data;
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter, checked against a queue-based reference model.
module tb_regfile_write_arbiter;
   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 8;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      bit          live;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   regfile_write_arbiter_if bus ();

   regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   ent_t        mq[$];
   int          m_cnt  = 0;
   bit          m_stall = 0;
   logic [4:0]  last_wr_addr;
   logic [31:0] last_wr_data;
   logic        last_stall;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, compare against the model at the falling edge, advance the model.
   task automatic step(input logic [4:0] aa, input logic [31:0] ad, input logic bv,
                       input logic [4:0] ba, input logic [31:0] bd, input logic [4:0] qa);
      bit          head_live, hw, byp, e_ready, e_pend, a_wr, popped, blocked;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      int          sz;
      bus.a_addr = aa; bus.a_data = ad; bus.b_valid = bv;
      bus.b_addr = ba; bus.b_data = bd; bus.q_addr = qa;
      @(negedge clk);
      sz = mq.size();
      head_live = (sz > 0) && mq[0].live;
      e_addr = 5'd0; e_data = 32'd0; hw = 0; byp = 0;
      if (m_stall) begin
         if (head_live) begin e_addr = mq[0].addr; e_data = mq[0].data; hw = 1; end
      end else if (aa != 5'd0) begin
         e_addr = aa; e_data = ad;
      end else if (head_live) begin
         e_addr = mq[0].addr; e_data = mq[0].data; hw = 1;
      end
`ifdef REGFILE_ARB_BYPASS_EN
      else if (sz == 0 && bv && ba != 5'd0) begin
         e_addr = ba; e_data = bd; byp = 1;
      end
`endif
      e_ready = (sz < DEPTH);
      e_pend = 0;
      if (qa != 5'd0)
         foreach (mq[i]) if (mq[i].live && mq[i].addr == qa) e_pend = 1;

      last_wr_addr = bus.wr_addr;
      last_wr_data = bus.wr_data;
      last_stall   = bus.stall_o;
      $display("cyc a=%0d b=%0b/%0d q=%0d -> wr=%0d:%0h rdy=%0b pend=%0b stall=%0b (model fifo=%0d)",
               aa, bv, ba, qa, bus.wr_addr, bus.wr_data, bus.b_ready, bus.q_pending, bus.stall_o, sz);
      check("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
      if (e_addr != 5'd0) check("wr_data", bus.wr_data, e_data);
      check("b_ready", 32'(bus.b_ready), 32'(e_ready));
      check("q_pending", 32'(bus.q_pending), 32'(e_pend));
      check("stall_o", 32'(bus.stall_o), 32'(m_stall));

      a_wr    = !m_stall && (aa != 5'd0);
      popped  = (sz > 0) && (!mq[0].live || hw);
      blocked = !m_stall && head_live && (aa != 5'd0);
      if (popped) void'(mq.pop_front());
      if (a_wr) foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 0;
      if (bv && e_ready && ba != 5'd0 && !byp)
         mq.push_back('{addr: ba, data: bd, live: !(a_wr && aa == ba)});
      if (popped || sz == 0) m_cnt = 0;
      else if (blocked) m_cnt++;
      m_stall = !m_stall && (m_cnt == STARVE_LIMIT);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
   endtask

   initial begin
      int first_stall;
      logic [4:0] ra;
      reset = 1'b1;
      bus.a_addr = 5'd7; bus.a_data = 32'h77; bus.b_valid = 1'b1;
      bus.b_addr = 5'd3; bus.b_data = 32'd1; bus.q_addr = 5'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      check("rst_b_ready", 32'(bus.b_ready), 32'd0);
      check("rst_stall", 32'(bus.stall_o), 32'd0);
      check("rst_q_pending", 32'(bus.q_pending), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic latency
      step(5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5);
      step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
      check("lat_fifo_empty", 32'(mq.size()), 32'd0);
      idle(2);

      // Fill while A is busy, then one more offer is refused
      for (int i = 1; i <= 4; i++) step(5'd7, 32'h70 + 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i), 5'd3);
      step(5'd7, 32'h75, 1'b1, 5'd5, 32'h105, 5'd3);
      check("fill_b_ready", 32'(bus.b_ready), 32'd0);
      idle(6);

      // Priority then drain in the first idle cycle
      step(5'd6, 32'h60, 1'b1, 5'd9, 32'h99, 5'd9);
      step(5'd6, 32'h61, 1'b0, 5'd0, 32'd0, 5'd9);
      step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);
      check("drain_wr_addr", 32'(last_wr_addr), 32'd9);
      step(5'd6, 32'h62, 1'b0, 5'd0, 32'd0, 5'd9);
      idle(2);

      // Squash: newer A write to 8 kills the buffered 0xAA
      step(5'd3, 32'h33, 1'b1, 5'd8, 32'hAA, 5'd8);
      step(5'd8, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd8);
      step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8);
      check("squash_pending", 32'(bus.q_pending), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8);
         check("squash_no_stale", 32'(last_wr_addr == 5'd8 && last_wr_data == 32'hAA), 32'd0);
      end

      // Starvation: head blocked by A every cycle
      step(5'd7, 32'h70, 1'b1, 5'd10, 32'hA0A0, 5'd10);
      first_stall = 0;
      for (int i = 1; i <= STARVE_LIMIT + 4; i++) begin
         step(5'd7, 32'h70, 1'b0, 5'd0, 32'd0, 5'd10);
         if (last_stall && first_stall == 0) begin
            first_stall = i;
            check("starve_wr_addr", 32'(last_wr_addr), 32'd10);
         end
      end
      check("starve_cycle", 32'(first_stall), 32'(STARVE_LIMIT + 1));
      idle(2);

      // Asynchronous reset mid-cycle with three entries buffered
      for (int i = 0; i < 3; i++) step(5'd7, 32'h70, 1'b1, 5'(11 + i), 32'hC0 + 32'(i), 5'd11);
      bus.b_valid = 1'b0; bus.a_addr = 5'd7; bus.q_addr = 5'd11;
      #2;
      reset = 1'b1;
      #1;
      check("arst_wr_addr", 32'(bus.wr_addr), 32'd0);
      check("arst_stall", 32'(bus.stall_o), 32'd0);
      check("arst_b_ready", 32'(bus.b_ready), 32'd0);
      check("arst_q_pending", 32'(bus.q_pending), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mq.delete(); m_cnt = 0; m_stall = 0;
      bus.a_addr = 5'd0;
      #1;
      check("arst_rel_b_ready", 32'(bus.b_ready), 32'd1);
      for (int q = 0; q < 32; q++) begin
         bus.q_addr = 5'(q);
         #0.1;
         check("arst_rel_pending", 32'(bus.q_pending), 32'd0);
      end
      @(posedge clk);
      #1;

      // Randomized traffic, light then heavy A load
      for (int i = 0; i < 300; i++) begin
         ra = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
         step(ra, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)));
      end
      for (int i = 0; i < 300; i++) begin
         ra = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         step(ra, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)));
      end
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (write address + write data; address 0 means no write) between two sources.
- Source A is the pipeline writeback stage. It has priority and no handshake.
- Source B is a multi-cycle unit (mult/div, uncached load) with valid/ready. B results are buffered in a small FIFO and drained into idle write-port cycles.
- The block provides pending-write hazard lookup, stale-write squashing and an anti-starvation pipeline stall.

Parameters:
- DEPTH, 4: B FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8: number of consecutive cycles the FIFO head may be blocked by A before a stall is raised; range 1..255.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- a_addr  in  5  pipeline WB destination; 0 = no write
- a_data  in  32  pipeline WB data
- b_valid  in  1  B result valid
- b_ready  out  1  B result accepted this cycle
- b_addr  in  5  B destination
- b_data  in  32  B data
- q_addr  in  5  hazard query register
- q_pending  out  1  q_addr has a live (non-squashed) entry in the FIFO
- stall_o  out  1  freeze request to the pipeline
- wr_addr  out  5  to register file write address
- wr_data  out  32  to register file write data

Behaviour:
- Reset: FIFO emptied, all entries marked dead, wait counter = 0, stall_o = 0, wr_addr = 0, wr_data = 0, b_ready = 0 while reset is high. Reset mid-operation discards buffered B writes.
- FIFO state: circular buffer with rd/wr pointers and count (0..DEPTH). Each entry holds {live, addr, data}.
- b_ready = (count < DEPTH), evaluated from registered state only; it does not depend on a same-cycle pop.
- Push: occurs on b_valid && b_ready.
  - b_addr = 0: handshake completes, nothing is enqueued.
  - Otherwise: enqueue {live=1, b_addr, b_data}.
- Port mux (combinational):
  - stall_o = 1: wr = FIFO head if the head is live, else wr_addr = 0. a_addr is ignored because the pipeline is frozen and re-presents the same write next cycle.
  - else if a_addr != 0: wr = A.
  - else if count > 0 and the head is live: wr = head.
  - else: wr_addr = 0.
- Pop: the head is popped whenever it was written this cycle, or it is dead (a dead head pops for free in any cycle).
- Simultaneous push and pop: count unchanged. Pushing when count = DEPTH is impossible (b_ready = 0).
- Squash (WAW): when A writes register R (a_addr = R != 0, stall_o = 0), every live FIFO entry with addr R is marked dead at the clock edge. This includes an entry pushed the same cycle. The older B value must never overwrite the newer A value.
- q_pending: combinational OR over live entries whose addr == q_addr. q_addr = 0 gives 0. Entries pushed this cycle are not visible until the next cycle.
- Starvation:
  - Counter increments each cycle the head is live and blocked by A (a_addr != 0).
  - The counter resets to 0 on a pop or when count = 0.
  - When counter = STARVE_LIMIT, stall_o is registered high for exactly 1 cycle, the head drains, and the counter clears.
- Latency: a B write accepted at edge k appears on wr_* in cycle k+1 at the earliest, when A is idle.
- wr_data is don't-care when wr_addr = 0, but the bench checks only wr_addr in that case.

Optional Feature:
- Macro: REGFILE_ARB_BYPASS_EN.
- Defined: when count = 0, stall_o = 0, a_addr = 0, b_valid = 1 and b_addr != 0, the B write drives wr_* in the same cycle and is not enqueued. Zero-cycle latency; b_ready = 1.
- Undefined: B writes are always enqueued; minimum latency is 1 cycle.

Test Plan:
- Reset, then b_valid with b_addr=5, b_data=0x1234 while a_addr=0 → next cycle wr_addr=5, wr_data=0x1234 (same cycle with bypass); FIFO empty afterwards.
- Fill: 4 B pushes (addr 1..4) while a_addr=7 every cycle → b_ready drops to 0 after 4 accepts; q_addr=3 gives q_pending=1.
- Priority/drain: FIFO holds addr 9; a_addr=0 then 6 alternating → A wins when its addr != 0, entry 9 written in the first idle cycle.
- Squash: FIFO holds addr 8 = 0xAA; A writes 8 = 0xBB → q_pending(8)=0, and register 8 never receives 0xAA afterwards.
- Starvation: FIFO head live, a_addr != 0 continuously → stall_o=1 for one cycle at cycle STARVE_LIMIT(8)+1, head written in that cycle.
- Async reset asserted mid-cycle with 3 entries queued → wr_addr=0, stall_o=0 immediately; after release b_ready=1, q_pending=0 for all addresses.
